pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the datapath program counter; run/pause/step control, halt sentinel, misalignment fault, retired count.
// Latency: pc and retired update one clk edge after the inputs are sampled; status flags are decoded from the state register.
// Backpressure: halt_req pauses the PC; step advances one instruction per cycle while held; HALT/FAULT freeze until rst_n.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, step, halt_req level-sensitive run / single-step / pause controls
//   pcf_in                next PC from the datapath (pc+4, branch or jump target)
//   instruction           instruction word currently fetched at pc
//   pc                    registered program counter
//   pc_valid              high in RUN and PAUSE
//   halted, fault         high in HALT / FAULT respectively
//   retired               count of PC updates taken, saturating at 16'hFFFF
module pc_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'd4,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        step,
   input  logic        halt_req,
   input  logic [31:0] pcf_in,
   input  logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic        halted,
   output logic        fault,
   output logic [15:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_HALT  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t state;

   // Advance-check decode; halt sentinel outranks misalignment.
   logic is_halt_word;
   logic is_misaligned;

   assign is_halt_word  = (instruction == HALT_WORD);
   assign is_misaligned = (pcf_in[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         retired <= 16'd0;
      end else begin
         case (state)
            S_IDLE: begin
               pc <= RESET_PC;
               // start only arms the sequencer; the first update happens next edge.
               if (start) begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (halt_req) begin
                  state <= S_PAUSE;
               end else if (is_halt_word) begin
                  state <= S_HALT;
               end else if (is_misaligned) begin
                  state <= S_FAULT;
               end else begin
                  pc <= pcf_in;
                  if (retired != 16'hFFFF) begin
                     retired <= retired + 16'd1;
                  end
               end
            end
            S_PAUSE: begin
               // start beats step; resuming takes an edge with no update.
               if (start) begin
                  state <= S_RUN;
               end else if (step) begin
                  if (is_halt_word) begin
                     state <= S_HALT;
                  end else if (is_misaligned) begin
                     state <= S_FAULT;
                  end else begin
                     pc <= pcf_in;
                     if (retired != 16'hFFFF) begin
                        retired <= retired + 16'd1;
                     end
                  end
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               state <= S_IDLE;
               pc    <= RESET_PC;
            end
         endcase
      end
   end

   assign pc_valid = (state == S_RUN) || (state == S_PAUSE);
   assign halted   = (state == S_HALT);
   assign fault    = (state == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential run, halt sentinel, misaligned fault,
// pause/step, control priorities, PC wrap, asynchronous mid-run reset and retired saturation.
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        step;
   logic        halt_req;
   logic [31:0] pcf_in;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        pc_valid;
   logic        halted;
   logic        fault;
   logic [15:0] retired;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_pc;
   logic [15:0] exp_ret;

   pc_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .step        (step),
      .halt_req    (halt_req),
      .pcf_in      (pcf_in),
      .instruction (instruction),
      .pc          (pc),
      .pc_valid    (pc_valid),
      .halted      (halted),
      .fault       (fault),
      .retired     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [15:0] e_ret,
                            input logic e_vld, input logic e_halt, input logic e_fault);
      check({tag, ".pc"}, pc, e_pc);
      check({tag, ".retired"}, {16'd0, retired}, {16'd0, e_ret});
      check({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e_vld});
      check({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halt});
      check({tag, ".fault"}, {31'd0, fault}, {31'd0, e_fault});
   endtask

   task automatic do_reset();
      start       = 1'b0;
      step        = 1'b0;
      halt_req    = 1'b0;
      instruction = 32'h0000_0013;
      pcf_in      = 32'd0;
      rst_n       = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      exp_pc  = 32'd4;
      exp_ret = 16'd0;
   endtask

   // IDLE -> RUN; the start edge itself performs no update.
   task automatic go_run();
      start  = 1'b1;
      pcf_in = exp_pc + 32'd4;
      tick();
      start = 1'b0;
   endtask

   // Sequential advance: pcf_in = pc + 4 for n edges.
   task automatic run_seq(input int n);
      for (int i = 0; i < n; i++) begin
         pcf_in = exp_pc + 32'd4;
         tick();
         exp_pc = exp_pc + 32'd4;
         if (exp_ret != 16'hFFFF) exp_ret = exp_ret + 16'd1;
      end
   endtask

   initial begin
      // ---- Reset state ----
      do_reset();
      check_all("reset", 32'd4, 16'd0, 1'b0, 1'b0, 1'b0);

      // IDLE ignores step.
      step   = 1'b1;
      pcf_in = 32'd8;
      tick();
      step = 1'b0;
      check_all("idle_step", 32'd4, 16'd0, 1'b0, 1'b0, 1'b0);

      // ---- Sequential run: 4,8,12,16,20,24 ----
      go_run();
      check_all("start_edge", 32'd4, 16'd0, 1'b1, 1'b0, 1'b0);
      run_seq(1);
      check("seq1.pc", pc, 32'd8);
      run_seq(4);
      check_all("seq5", 32'd24, 16'd5, 1'b1, 1'b0, 1'b0);

      // ---- Halt sentinel at pc=16 ----
      do_reset();
      go_run();
      run_seq(3);
      check("pre_halt.pc", pc, 32'd16);
      instruction = 32'hFFFF_FFFF;
      pcf_in      = 32'd20;
      tick();
      check_all("halt", 32'd16, 16'd3, 1'b0, 1'b1, 1'b0);
      instruction = 32'h0000_0013;
      start       = 1'b1;
      tick();
      tick();
      start = 1'b0;
      check_all("halt_sticky", 32'd16, 16'd3, 1'b0, 1'b1, 1'b0);

      // ---- Misaligned branch at pc=8 ----
      do_reset();
      go_run();
      run_seq(1);
      pcf_in = 32'h0000_0022;
      tick();
      check_all("fault", 32'd8, 16'd1, 1'b0, 1'b0, 1'b1);
      start  = 1'b1;
      step   = 1'b1;
      pcf_in = 32'd12;
      tick();
      start = 1'b0;
      step  = 1'b0;
      check_all("fault_sticky", 32'd8, 16'd1, 1'b0, 1'b0, 1'b1);
      do_reset();
      check_all("fault_cleared", 32'd4, 16'd0, 1'b0, 1'b0, 1'b0);

      // ---- Pause / step ----
      go_run();
      run_seq(2);
      halt_req = 1'b1;
      pcf_in   = 32'd16;
      tick();
      halt_req = 1'b0;
      check_all("pause", 32'd12, 16'd2, 1'b1, 1'b0, 1'b0);
      tick();
      check("pause_hold.pc", pc, 32'd12);
      step   = 1'b1;
      pcf_in = 32'd40;
      tick();
      step = 1'b0;
      check_all("step1", 32'd40, 16'd3, 1'b1, 1'b0, 1'b0);
      pcf_in = 32'd44;
      tick();
      check("step_released.pc", pc, 32'd40);
      step = 1'b1;
      tick();
      check("held_step_a.pc", pc, 32'd44);
      pcf_in = 32'd48;
      tick();
      step = 1'b0;
      check_all("held_step_b", 32'd48, 16'd5, 1'b1, 1'b0, 1'b0);
      start  = 1'b1;
      pcf_in = 32'd52;
      tick();
      start = 1'b0;
      check_all("resume_edge", 32'd48, 16'd5, 1'b1, 1'b0, 1'b0);
      tick();
      check_all("resume_update", 32'd52, 16'd6, 1'b1, 1'b0, 1'b0);

      // ---- Priority: halt_req beats HALT_WORD in RUN ----
      halt_req    = 1'b1;
      instruction = 32'hFFFF_FFFF;
      pcf_in      = 32'd56;
      tick();
      halt_req    = 1'b0;
      instruction = 32'h0000_0013;
      check_all("halt_req_prio", 32'd52, 16'd6, 1'b1, 1'b0, 1'b0);
      // start beats step in PAUSE.
      start = 1'b1;
      step  = 1'b1;
      tick();
      start = 1'b0;
      step  = 1'b0;
      check_all("start_prio", 32'd52, 16'd6, 1'b1, 1'b0, 1'b0);
      tick();
      check_all("after_start_prio", 32'd56, 16'd7, 1'b1, 1'b0, 1'b0);
      // Step onto a sentinel from PAUSE.
      halt_req = 1'b1;
      pcf_in   = 32'd60;
      tick();
      halt_req = 1'b0;
      check("pause2.pc", pc, 32'd56);
      step        = 1'b1;
      instruction = 32'hFFFF_FFFF;
      tick();
      step        = 1'b0;
      instruction = 32'h0000_0013;
      check_all("step_halt", 32'd56, 16'd7, 1'b0, 1'b1, 1'b0);

      // ---- Natural wrap ----
      do_reset();
      go_run();
      pcf_in = 32'hFFFF_FFFC;
      tick();
      check("wrap_hi.pc", pc, 32'hFFFF_FFFC);
      pcf_in = 32'd0;
      tick();
      check_all("wrap_lo", 32'd0, 16'd2, 1'b1, 1'b0, 1'b0);

      // ---- Asynchronous reset mid-run at pc=100 ----
      pcf_in = 32'd100;
      tick();
      check("pre_arst.pc", pc, 32'd100);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_reset", 32'd4, 16'd0, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n   = 1'b1;
      exp_pc  = 32'd4;
      exp_ret = 16'd0;

      // ---- Retired saturation ----
      go_run();
      run_seq(65534);
      check("sat_pre.retired", {16'd0, retired}, 32'h0000_FFFE);
      run_seq(3);
      check_all("sat", exp_pc, 16'hFFFF, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
